decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage -- Y86-64 decode / write-back stage.
//
// Decodes source/destination register IDs from the D pipeline register, reads
// the 15-entry register file, resolves data hazards by forwarding and loads the
// E pipeline register. The register-file write port is driven from W.
//
// Build option:
//   DECODE_FWD_EN  defined   : full e/M/W forwarding chain.
//                  undefined : W-stage write-through only; the hazard unit must
//                              stall decode on any e/M dependency.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter logic [63:0] RSP_INIT = 64'd2048
) (
  input  logic        clk,
  input  logic        rst,
  // D pipeline register
  input  logic [3:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  // E register control
  input  logic        E_bubble,
  // Forwarding sources
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  // Source IDs for the hazard unit
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  // E pipeline register
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;
  localparam logic [3:0] STAT_AOK = 4'b1000;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    val_c: 64'd0,
    val_a: 64'd0,
    val_b: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE,
    src_a: RNONE,
    src_b: RNONE
  };

  logic [63:0] rf_q [15];
  logic [3:0]  dst_e, dst_m;
  logic [63:0] val_a, val_b;
  e_reg_t      e_d, e_q;

  // Register read with hazard resolution; first match in the chain wins.
  function automatic logic [63:0] read_src(input logic [3:0] src);
    if (src == RNONE)       return 64'd0;
`ifdef DECODE_FWD_EN
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
`endif
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_q[src];
  endfunction

`ifndef DECODE_FWD_EN
  // e/M sources are not consumed when forwarding is compiled out.
  logic unused_fwd;
  assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM};
`endif

  // Register-ID decode from icode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    d_srcA = RNONE;
    d_srcB = RNONE;
    dst_e  = RNONE;
    dst_m  = RNONE;
    unique case (D_icode)
      I_RRMOVQ: begin d_srcA = D_rA; dst_e = D_rB; end
      I_IRMOVQ: begin dst_e = D_rB; end
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB; dst_m = D_rA; end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; dst_e = D_rB; end
      I_CALL:   begin d_srcB = RSP; dst_e = RSP; end
      I_RET:    begin d_srcA = RSP; d_srcB = RSP; dst_e = RSP; end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP; dst_e = RSP; end
      I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; dst_e = RSP; dst_m = D_rA; end
      default:  ; // halt, nop, jXX and invalid codes use no registers
    endcase
  end

  // Operand selection: valP for call/jXX, otherwise the resolved source value.
  always_comb begin
    val_a = read_src(d_srcA);
    if (D_icode == I_CALL || D_icode == I_JXX) val_a = D_valP;
    val_b = read_src(d_srcB);
  end

  // Next E register contents: bubble or the decoded instruction.
  always_comb begin
    e_d = E_BUBBLE;
    if (!E_bubble) begin
      e_d.stat  = D_stat;
      e_d.icode = D_icode;
      e_d.ifun  = D_ifun;
      e_d.val_c = D_valC;
      e_d.val_a = val_a;
      e_d.val_b = val_b;
      e_d.dst_e = dst_e;
      e_d.dst_m = dst_m;
      e_d.src_a = d_srcA;
      e_d.src_b = d_srcB;
    end
  end

  // E pipeline register; reset loads a bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) e_q <= E_BUBBLE;
    else     e_q <= e_d;
  end

  // Register-file write port; the valM write is issued last so it wins on popq %rsp.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the architectural register file has defined reset values, so this array is reset.
      for (int i = 0; i < 15; i++) rf_q[i] <= (i == 4) ? RSP_INIT : 64'd0;
    end else begin
      if (W_dstE != RNONE) rf_q[W_dstE] <= W_valE;
      if (W_dstM != RNONE) rf_q[W_dstM] <= W_valM;
    end
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage -- scoreboard bench for decode_stage. Expected E register
// contents are queued when D is driven and compared one edge later.
// Follows DECODE_FWD_EN for the forwarding expectations.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam logic [3:0] F   = 4'hF;
  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;
  localparam logic [3:0] INS = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
  } e_t;

  typedef struct {
    e_t    v;
    string name;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.RSP_INIT(64'd2048)) dut (
    .clk(clk), .rst(rst),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  function automatic e_t mk(input logic [3:0] stat, input logic [3:0] icode,
                            input logic [3:0] ifun, input logic [63:0] val_c,
                            input logic [63:0] val_a, input logic [63:0] val_b,
                            input logic [3:0] dst_e, input logic [3:0] dst_m,
                            input logic [3:0] src_a, input logic [3:0] src_b);
    e_t r;
    r.stat = stat; r.icode = icode; r.ifun = ifun; r.val_c = val_c;
    r.val_a = val_a; r.val_b = val_b; r.dst_e = dst_e; r.dst_m = dst_m;
    r.src_a = src_a; r.src_b = src_b;
    return r;
  endfunction

  e_t bubble_v;
  initial bubble_v = mk(AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, F, F, F, F);

  task automatic clear_srcs();
    E_bubble = 1'b0;
    e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  task automatic drive_d(input logic [3:0] stat, input logic [3:0] icode,
                         input logic [3:0] ifun, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] valc,
                         input logic [63:0] valp);
    D_stat = stat; D_icode = icode; D_ifun = ifun; D_rA = ra; D_rB = rb;
    D_valC = valc; D_valP = valp;
  endtask

  task automatic expect_e(input e_t v, input string name);
    sb_t item;
    item.v = v;
    item.name = name;
    sb_q.push_back(item);
  endtask

  // Clock edge, then compare the oldest queued expectation against E.
  task automatic tick();
    sb_t item;
    e_t  obs;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      obs = {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
             E_dstE, E_dstM, E_srcA, E_srcB};
      n_checks++;
      if (obs !== item.v) begin
        n_fail++;
        $display("FAIL %s: E got %h, required %h", item.name, obs, item.v);
      end
    end
  endtask

  task automatic check_src(input logic [3:0] exp_a, input logic [3:0] exp_b,
                           input string name);
    #1;
    n_checks++;
    if ({d_srcA, d_srcB} !== {exp_a, exp_b}) begin
      n_fail++;
      $display("FAIL %s: d_srcA/B got %h/%h, required %h/%h",
               name, d_srcA, d_srcB, exp_a, exp_b);
    end
  endtask

  // Reset loads a bubble, blocks RF writes and leaves %rsp at RSP_INIT.
  task automatic test_reset();
    rst = 1'b1;
    clear_srcs();
    drive_d(AOK, 4'h6, 4'h0, 4'h1, 4'h2, 64'h11, 64'h22);
    W_dstE = 4'h5; W_valE = 64'hDEAD;
    expect_e(bubble_v, "reset_edge0"); tick();
    expect_e(bubble_v, "reset_edge1"); tick();
    rst = 1'b0;
    clear_srcs();
    drive_d(AOK, 4'h9, 4'h0, F, F, 64'd0, 64'h30);
    check_src(4'h4, 4'h4, "reset_dsrc_ret");
    expect_e(mk(AOK, 4'h9, 4'h0, 64'd0, 64'd2048, 64'd2048, 4'h4, F, 4'h4, 4'h4),
             "reset_rsp_init");
    tick();
    drive_d(AOK, 4'h2, 4'h0, 4'h5, 4'h6, 64'd0, 64'd0);
    expect_e(mk(AOK, 4'h2, 4'h0, 64'd0, 64'd0, 64'd0, 4'h6, F, 4'h5, F),
             "reset_blocks_write");
    tick();
  endtask

  // W write is visible through write-through, then from the array.
  task automatic test_wb_read();
    clear_srcs();
    W_dstE = 4'h2; W_valE = 64'h55;
    drive_d(AOK, 4'h6, 4'h1, 4'h2, 4'h2, 64'd0, 64'd0);
    expect_e(mk(AOK, 4'h6, 4'h1, 64'd0, 64'h55, 64'h55, 4'h2, F, 4'h2, 4'h2),
             "wb_same_cycle");
    tick();
    clear_srcs();
    drive_d(AOK, 4'h2, 4'h0, 4'h2, 4'h3, 64'd0, 64'd0);
    expect_e(mk(AOK, 4'h2, 4'h0, 64'd0, 64'h55, 64'd0, 4'h3, F, 4'h2, F),
             "wb_from_array");
    tick();
  endtask

  // Forwarding priority chain; without DECODE_FWD_EN only W sources apply.
  task automatic test_forwarding();
    logic [63:0] exp_v;
    clear_srcs();
    e_dstE = 4'h1; e_valE = 64'h10;
    M_dstE = 4'h1; M_valE = 64'h20;
    W_dstE = 4'h1; W_valE = 64'h30;
    drive_d(AOK, 4'h6, 4'h0, 4'h1, 4'h1, 64'd0, 64'd0);
`ifdef DECODE_FWD_EN
    exp_v = 64'h10;
`else
    exp_v = 64'h30;
`endif
    expect_e(mk(AOK, 4'h6, 4'h0, 64'd0, exp_v, exp_v, 4'h1, F, 4'h1, 4'h1), "fwd_e_first");
    tick();
    e_dstE = F;
`ifdef DECODE_FWD_EN
    exp_v = 64'h20;
`else
    exp_v = 64'h30;
`endif
    expect_e(mk(AOK, 4'h6, 4'h0, 64'd0, exp_v, exp_v, 4'h1, F, 4'h1, 4'h1), "fwd_m_vale");
    tick();
    M_dstM = 4'h1; m_valM = 64'h40;
    W_dstM = 4'h1; W_valM = 64'h50;
`ifdef DECODE_FWD_EN
    exp_v = 64'h40;
`else
    exp_v = 64'h50;
`endif
    expect_e(mk(AOK, 4'h6, 4'h0, 64'd0, exp_v, exp_v, 4'h1, F, 4'h1, 4'h1), "fwd_m_valm");
    tick();
    // reg1 now holds 0x50; srcA=F must read 0 even with live sources on F.
    clear_srcs();
    e_valE = 64'h99; W_valE = 64'h77;
    drive_d(AOK, 4'h6, 4'h3, F, 4'h1, 64'd0, 64'd0);
    expect_e(mk(AOK, 4'h6, 4'h3, 64'd0, 64'd0, 64'h50, 4'h1, F, F, 4'h1), "fwd_rnone");
    tick();
  endtask

  // Simultaneous E and M writes to %rsp: the valM value wins.
  task automatic test_popq();
    clear_srcs();
    W_dstE = 4'h4; W_valE = 64'h100;
    W_dstM = 4'h4; W_valM = 64'h200;
    drive_d(AOK, 4'hA, 4'h0, 4'h4, F, 64'd0, 64'd0);
    expect_e(mk(AOK, 4'hA, 4'h0, 64'd0, 64'h200, 64'h200, 4'h4, F, 4'h4, 4'h4),
             "popq_write_through");
    tick();
    clear_srcs();
    drive_d(AOK, 4'h9, 4'h0, F, F, 64'd0, 64'd0);
    expect_e(mk(AOK, 4'h9, 4'h0, 64'd0, 64'h200, 64'h200, 4'h4, F, 4'h4, 4'h4),
             "popq_array");
    tick();
  endtask

  // call and jXX take valA from valP.
  task automatic test_call();
    clear_srcs();
    drive_d(AOK, 4'h8, 4'h0, F, F, 64'h40, 64'h13);
    check_src(F, 4'h4, "call_dsrc");
    expect_e(mk(AOK, 4'h8, 4'h0, 64'h40, 64'h13, 64'h200, 4'h4, F, F, 4'h4), "call");
    tick();
    drive_d(AOK, 4'h7, 4'h3, F, F, 64'h123, 64'h99);
    expect_e(mk(AOK, 4'h7, 4'h3, 64'h123, 64'h99, 64'd0, F, F, F, F), "jxx");
    tick();
  endtask

  // E_bubble overrides D for one edge only.
  task automatic test_bubble();
    clear_srcs();
    drive_d(AOK, 4'h3, 4'h0, F, 4'h7, 64'h7777, 64'd0);
    E_bubble = 1'b1;
    expect_e(bubble_v, "bubble"); tick();
    E_bubble = 1'b0;
    expect_e(mk(AOK, 4'h3, 4'h0, 64'h7777, 64'd0, 64'd0, 4'h7, F, F, F), "bubble_release");
    tick();
  endtask

  // Consecutive instructions, including invalid and halt codes.
  task automatic test_back_to_back();
    clear_srcs();
    drive_d(AOK, 4'h5, 4'h0, 4'h8, 4'h2, 64'h18, 64'd0);
    expect_e(mk(AOK, 4'h5, 4'h0, 64'h18, 64'd0, 64'h55, F, 4'h8, F, 4'h2), "b2b_mrmovq");
    tick();
    drive_d(AOK, 4'h4, 4'h0, 4'h1, 4'h4, 64'h8, 64'd0);
    expect_e(mk(AOK, 4'h4, 4'h0, 64'h8, 64'h50, 64'h200, F, F, 4'h1, 4'h4), "b2b_rmmovq");
    tick();
    drive_d(AOK, 4'hB, 4'h0, 4'h3, F, 64'd0, 64'd0);
    expect_e(mk(AOK, 4'hB, 4'h0, 64'd0, 64'h200, 64'h200, 4'h4, 4'h3, 4'h4, 4'h4), "b2b_popq");
    tick();
    drive_d(INS, 4'hC, 4'h5, 4'h1, 4'h2, 64'hABC, 64'hDEF);
    check_src(F, F, "b2b_invalid_dsrc");
    expect_e(mk(INS, 4'hC, 4'h5, 64'hABC, 64'd0, 64'd0, F, F, F, F), "b2b_invalid");
    tick();
    drive_d(HLT, 4'h0, 4'h0, 4'h1, 4'h2, 64'd0, 64'd0);
    expect_e(mk(HLT, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, F, F, F, F), "b2b_halt");
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wb_read();
    test_forwarding();
    test_popq();
    test_call();
    test_bubble();
    test_back_to_back();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
